seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 114 +++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential 32-bit unsigned divider: radix-2 restoring, one quotient bit per cycle.
// Three-state control (IDLE/RUN/DONE) with registered busy/done and held results.
module seq_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic        accept;
  logic        last_step;

  // Working datapath: partial remainder, dividend/quotient shifter, divisor.
  logic [31:0] rem_p0;
  logic [31:0] dvd_p0;
  logic [31:0] dvs_p0;
  logic [31:0] rem_nxt;
  logic        qbit_nxt;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [32:0] div_step(input logic [31:0] rem,
                                           input logic        bit_in,
                                           input logic [31:0] dvs);
    logic [32:0] sh;
    logic [32:0] diff;
    sh   = {rem, bit_in};
    diff = sh - {1'b0, dvs};
    if (sh >= {1'b0, dvs})
      return {diff[31:0], 1'b1};
    else
      return {sh[31:0], 1'b0};
  endfunction

  assign accept    = (state != RUN) && start;
  assign last_step = (state == RUN) && (cnt == 6'd31);

  always_comb begin
    {rem_nxt, qbit_nxt} = div_step(rem_p0, dvd_p0[31], dvs_p0);
  end

  // Datapath registers carry no reset; they are reloaded on every accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_p0 <= '0;
      dvd_p0 <= dividend;
      dvs_p0 <= divisor;
    end else if (state == RUN) begin
      rem_p0 <= rem_nxt;
      dvd_p0 <= {dvd_p0[30:0], qbit_nxt};
    end
  end

  // Control FSM and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            cnt <= '0;
            if (divisor == 32'd0) begin
              // Zero divisor resolves immediately without entering RUN.
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= 32'hFFFF_FFFF;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          cnt <= cnt + 6'd1;
          if (last_step) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= {dvd_p0[30:0], qbit_nxt};
            remainder   <= rem_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
